pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Producer side of the ID/EX (and IF/ID, PC) stall/flush interface.
- Detects load-use hazards, taken branches/jumps resolved in EX, and EBREAK reaching EX.
- Drives pc_en, ifid_en, ifid_flush, idex_stall and idex_flush for the 5-stage RV32I pipeline.
- Holds an FSM for multi-cycle load stalls and debug halt, plus saturating event counters for performance monitoring.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- LOAD_SRC, 2'b01, RUDataWrSrc encoding that marks a load in EX.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  rd of the instruction in EX.
- ex_ruwr  in  1  EX instruction writes the register file.
- ex_rudatawrsrc  in  2  EX write-back source select.
- ex_br_taken  in  1  EX resolved a taken branch or jump this cycle.
- ex_ebreak  in  1  EX holds EBREAK.
- resume  in  1  single-cycle pulse that leaves HALT.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID register update enable.
- ifid_flush  out  1  IF/ID register clear.
- idex_stall  out  1  bubble into ID/EX (takes priority over flush in ID/EX).
- idex_flush  out  1  ID/EX register clear.
- halted  out  1  FSM is in HALT.
- stall_cnt  out  CNT_W  total load-use bubble cycles.
- flush_cnt  out  CNT_W  total taken-branch flush events.

Behaviour:
- FSM states: RUN, STALL, HALT. Reset → RUN, stall counter = 0, stall_cnt = 0, flush_cnt = 0. Reset is honoured mid-stall and mid-halt.
- While rst=1, combinational outputs take their RUN/no-hazard values: pc_en=1, ifid_en=1, all flush/stall outputs 0, halted=0.
- hazard = ex_ruwr & (ex_rudatawrsrc==LOAD_SRC) & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN priority, highest first, outputs combinational in the same cycle:
  - ex_ebreak: pc_en=0, ifid_en=0, idex_flush=1; next state HALT.
  - ex_br_taken: ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt+1; stay RUN. Suppresses any hazard.
  - hazard: pc_en=0, ifid_en=0, idex_stall=1; stall_cnt+1. If LOAD_STALL_CYCLES>1, next state STALL with counter = LOAD_STALL_CYCLES-1.
  - otherwise: pc_en=1, ifid_en=1, all flush/stall outputs 0.
- STALL:
  - pc_en=0, ifid_en=0, idex_stall=1; stall_cnt+1; counter−1.
  - Return to RUN when the counter reaches 1 (the cycle of counter==1 is the last bubble).
  - ex_br_taken and ex_ebreak are ignored here, since EX holds bubbles.
- HALT:
  - pc_en=0, ifid_en=0, idex_stall=1, halted=1.
  - resume → RUN next cycle; halted falls in that same next cycle.
  - resume outside HALT is ignored.
- Counters saturate at all-ones; they never wrap.
- Total bubbles per hazard = LOAD_STALL_CYCLES exactly.
- Registered outputs: halted, stall_cnt, flush_cnt. All other outputs are combinational from state and inputs.

Test Plan:
- Load-use, default params: ex_rudatawrsrc=01, ex_ruwr=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → same cycle pc_en=0, ifid_en=0, idex_stall=1 for exactly 1 cycle; stall_cnt=1; next cycle all enables 1.
- False hazards: ex_rd=0 with id_rs1=0, or id_use_rs2=0 with id_rs2==ex_rd, or ex_rudatawrsrc=00 → no stall, stall_cnt stays 0.
- LOAD_STALL_CYCLES=3, hazard asserted for one cycle → idex_stall high 3 consecutive cycles, stall_cnt=3, back to RUN.
- ex_br_taken=1 together with a load-use hazard → ifid_flush=1, idex_flush=1, idex_stall=0, pc_en=1; flush_cnt=1, stall_cnt=0.
- ex_ebreak=1 → idex_flush=1 that cycle; halted=1 from next cycle with pc_en=0 held for 10 cycles; resume pulse → halted=0 and pc_en=1 the following cycle.
- rst asserted while in STALL (LOAD_STALL_CYCLES=4, 2nd bubble) or HALT → immediately pc_en=1, halted=0, counters 0. Saturation check with CNT_W=2: 5 hazards → stall_cnt=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipeline. It produces the PC and IF/ID
// enables and the IF/ID and ID/EX stall/flush controls, and counts stall and flush events.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter logic [1:0]  LOAD_SRC          = 2'b01,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_ruwr,
  input  logic [1:0]       ex_rudatawrsrc,
  input  logic             ex_br_taken,
  input  logic             ex_ebreak,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0]       STALL_LOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_nxt;
  logic [2:0] bub_cnt, bub_cnt_nxt;
  logic       hazard;
  logic       stall_inc;
  logic       flush_inc;

  assign hazard = ex_ruwr && (ex_rudatawrsrc == LOAD_SRC) && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_nxt   = state;
    bub_cnt_nxt = bub_cnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    // In reset the pipeline sees free-running, hazard-free controls.
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (ex_ebreak) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_nxt  = HALT;
          end else if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_stall = 1'b1;
            stall_inc  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt   = STALL;
              bub_cnt_nxt = STALL_LOAD;
            end
          end
        end
        STALL: begin
          // EX only holds bubbles here, so branch and ebreak are not looked at.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_stall  = 1'b1;
          stall_inc   = 1'b1;
          bub_cnt_nxt = bub_cnt - 3'd1;
          if (bub_cnt == 3'd1) state_nxt = RUN;
        end
        HALT: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_stall = 1'b1;
          if (resume) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      bub_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign halted = (state == HALT);

endmodule
